// File: rtl/simeck_pkg.sv
// Shared definitions for the Simeck32/64 key schedule and datapath:
// default word width, round constant, FSM states and the round function f.
package simeck_pkg;

    localparam int DEF_WORD_W = 16;

    // Round constant C = 2^n - 4.
    localparam logic [DEF_WORD_W-1:0] DEF_C = 16'hFFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } ks_state_t;

    // Left rotate in DEF_WORD_W bits.
    function automatic logic [DEF_WORD_W-1:0] rotl(input logic [DEF_WORD_W-1:0] x,
                                                   input int r);
        return (x << r) | (x >> (DEF_WORD_W - r));
    endfunction

    // f(x) = (x & rotl(x,5)) ^ rotl(x,1) for the default word width.
    function automatic logic [DEF_WORD_W-1:0] round_f(input logic [DEF_WORD_W-1:0] x);
        return (x & rotl(x, 5)) ^ rotl(x, 1);
    endfunction

endpackage

// File: rtl/simeck_round_f.sv
// Combinational Simeck round function f(x) = (x & rotl(x,ROT_A)) ^ rotl(x,ROT_B).
// Shared by the key schedule and the encrypt/decrypt datapath.
module simeck_round_f #(
    parameter int WORD_W = 16,
    parameter int ROT_A  = 5,
    parameter int ROT_B  = 1
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    logic [WORD_W-1:0] rot_a;
    logic [WORD_W-1:0] rot_b;

    assign rot_a = (x << ROT_A) | (x >> (WORD_W - ROT_A));
    assign rot_b = (x << ROT_B) | (x >> (WORD_W - ROT_B));
    assign y     = (x & rot_a) ^ rot_b;

endmodule

// File: rtl/simeck_key_schedule.sv
// Simeck32/64 round-key generator. Loads a master key, primes the external
// z-sequence LFSR for one cycle, then streams NUM_ROUNDS round keys on
// consecutive cycles followed by a one-cycle done pulse.
// Optional macro SIMECK_KS_KEY_ZEROIZE_EN: clear the key registers in DONE and
// force rk_out to zero whenever no round key is valid.
module simeck_key_schedule
    import simeck_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int NUM_ROUNDS = 32,
    parameter int ROT_A      = 5,
    parameter int ROT_B      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4*WORD_W-1:0] key_in,
    output logic              start_ready,
    output logic              lfsr_set,
    input  logic              z_in,
    output logic              rk_valid,
    output logic [WORD_W-1:0] rk_out,
    output logic [4:0]        rk_idx,
    output logic              done
);

    localparam logic [WORD_W-1:0] C          = ~WORD_W'(3);
    localparam logic [4:0]        LAST_ROUND = 5'(NUM_ROUNDS - 1);

    ks_state_t         state;
    ks_state_t         state_next;
    logic [WORD_W-1:0] k0, t0, t1, t2;
    logic [WORD_W-1:0] f_t0;
    logic [4:0]        rnd;

    simeck_round_f #(
        .WORD_W (WORD_W),
        .ROT_A  (ROT_A),
        .ROT_B  (ROT_B)
    ) u_round_f (
        .x (t0),
        .y (f_t0)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; busy-time start requests are simply dropped.
    // NOTE: state_next gets its default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PRIME;
            PRIME:   state_next = RUN;
            RUN:     if (rnd == LAST_ROUND) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Key-word shift register and round counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k0  <= '0;
            t0  <= '0;
            t1  <= '0;
            t2  <= '0;
            rnd <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    k0  <= key_in[WORD_W-1:0];
                    t0  <= key_in[2*WORD_W-1:WORD_W];
                    t1  <= key_in[3*WORD_W-1:2*WORD_W];
                    t2  <= key_in[4*WORD_W-1:3*WORD_W];
                    rnd <= '0;
                end
                RUN: begin
                    k0 <= t0;
                    t0 <= t1;
                    t1 <= t2;
                    t2 <= k0 ^ f_t0 ^ C ^ {{(WORD_W-1){1'b0}}, z_in};
                    if (rnd != LAST_ROUND) rnd <= rnd + 5'd1;
                end
`ifdef SIMECK_KS_KEY_ZEROIZE_EN
                DONE: begin
                    k0 <= '0;
                    t0 <= '0;
                    t1 <= '0;
                    t2 <= '0;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef SIMECK_KS_KEY_ZEROIZE_EN
    assign rk_out = (state == RUN) ? k0 : '0;
`else
    logic [WORD_W-1:0] rk_hold;

    // Remember the most recent round key so rk_out holds it outside RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             rk_hold <= '0;
        else if (state == RUN)  rk_hold <= k0;
    end

    assign rk_out = (state == RUN) ? k0 : rk_hold;
`endif

    assign start_ready = (state == IDLE);
    assign lfsr_set    = (state == PRIME);
    assign rk_valid    = (state == RUN);
    assign done        = (state == DONE);
    assign rk_idx      = rnd;

endmodule

// File: tb/tb_simeck_key_schedule.sv
// Self-checking bench for simeck_key_schedule: a cycle-timeline model of the
// key schedule plus a z-sequence LFSR model, compared every cycle, plus
// hand-computed round keys for the known test key.
`timescale 1ns/1ps
module tb_simeck_key_schedule;

    localparam int W  = 16;
    localparam int NR = 32;
    localparam logic [63:0] KEY_A = 64'h1918_1110_0908_0100;
    localparam logic [63:0] KEY_B = 64'hDEAD_BEEF_0123_4567;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [63:0]   key_in;
    logic          start_ready;
    logic          lfsr_set;
    logic          z_in;
    logic          rk_valid;
    logic [W-1:0]  rk_out;
    logic [4:0]    rk_idx;
    logic          done;

    simeck_key_schedule dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .key_in      (key_in),
        .start_ready (start_ready),
        .lfsr_set    (lfsr_set),
        .z_in        (z_in),
        .rk_valid    (rk_valid),
        .rk_out      (rk_out),
        .rk_idx      (rk_idx),
        .done        (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- z-sequence LFSR model (x^5 + x^2 + 1, seed 11111) ----
    bit zs[31];
    int zptr = 0;

    initial begin
        for (int n = 0; n < 5; n++) zs[n] = 1'b1;
        for (int n = 5; n < 31; n++) zs[n] = zs[n-3] ^ zs[n-5];
    end

    always @(posedge clk) begin
        if (lfsr_set) zptr <= 0;
        else          zptr <= (zptr + 1) % 31;
    end

    assign z_in = zs[zptr];

    // ---------------- round-key model ----------------
    logic [W-1:0] exp_rk[NR];

    function automatic logic [W-1:0] mrotl(input logic [W-1:0] x, input int r);
        logic [W-1:0] y;
        for (int b = 0; b < W; b++) y[(b + r) % W] = x[b];
        return y;
    endfunction

    function automatic logic [W-1:0] mf(input logic [W-1:0] x);
        return (x & mrotl(x, 5)) ^ mrotl(x, 1);
    endfunction

    function automatic void compute_keys(input logic [63:0] key);
        logic [W-1:0] w[NR+4];
        for (int i = 0; i < 4; i++) w[i] = key[16*i +: 16];
        for (int i = 0; i < NR; i++)
            w[i+4] = w[i] ^ mf(w[i+1]) ^ 16'hFFFC ^ {15'd0, zs[i % 31]};
        for (int i = 0; i < NR; i++) exp_rk[i] = w[i];
    endfunction

    // Timeline: mcyc = cycles since the accepting edge (-1 = idle).
    int           mcyc   = -1;
    logic [W-1:0] m_hold = '0;
    logic [4:0]   m_idx  = '0;
    int           done_seen = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcyc   = -1;
            m_hold = '0;
            m_idx  = '0;
        end else if (mcyc < 0) begin
            if (start) begin
                mcyc  = 1;
                m_idx = '0;
                compute_keys(key_in);
            end
        end else if (mcyc == NR + 2) begin
            mcyc = -1;
        end else begin
            mcyc++;
            if (mcyc >= 2 && mcyc <= NR + 1) m_idx = 5'(mcyc - 2);
`ifndef SIMECK_KS_KEY_ZEROIZE_EN
            if (mcyc == NR + 2) m_hold = exp_rk[NR-1];
`endif
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic [W-1:0] exp_out;
        exp_out = (mcyc >= 2 && mcyc <= NR + 1) ? exp_rk[mcyc-2] : m_hold;
        check("start_ready", 32'(start_ready), 32'(mcyc < 0));
        check("lfsr_set",    32'(lfsr_set),    32'(mcyc == 1));
        check("rk_valid",    32'(rk_valid),    32'(mcyc >= 2 && mcyc <= NR + 1));
        check("done",        32'(done),        32'(mcyc == NR + 2));
        check("rk_idx",      32'(rk_idx),      32'(m_idx));
        check("rk_out",      32'(rk_out),      32'(exp_out));
`ifdef SIMECK_KS_KEY_ZEROIZE_EN
        if (mcyc < 0)
            check("key_regs_zero", 32'(dut.k0 | dut.t0 | dut.t1 | dut.t2), 32'd0);
`endif
        if (done) done_seen++;
    end

    task automatic wait_done();
        bit seen = 1'b0;
        for (int c = 0; c < 80 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_timeout", 32'(seen), 32'd1);
    endtask

    logic [W-1:0] pin[6];

    initial begin
        pin[0] = 16'h0100; pin[1] = 16'h0908; pin[2] = 16'h1110;
        pin[3] = 16'h1918; pin[4] = 16'hEDED; pin[5] = 16'hD4D5;

        reset  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_rk_out",      32'(rk_out),      32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Run 1: known key, hand-computed first six round keys, busy start.
        done_seen = 0;
        start  = 1'b1;
        key_in = KEY_A;
        @(negedge clk);
        start = 1'b0;
        check("prime_lfsr_set", 32'(lfsr_set), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("pin_dut_rk", 32'(rk_out), 32'(pin[i]));
            check("pin_dut_idx", 32'(rk_idx), i);
            check("pin_model_rk", 32'(exp_rk[i]), 32'(pin[i]));
        end
        repeat (3) @(negedge clk);
        start  = 1'b1;
        key_in = KEY_B;
        @(negedge clk);
        start  = 1'b0;
        key_in = KEY_A;
        wait_done();

        // Back-to-back: start raised while DONE, accepted once IDLE returns.
        start = 1'b1;
        @(negedge clk);
        check("b2b_ready", 32'(start_ready), 32'd1);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("run1_done_count", done_seen, 1);
        done_seen = 0;

        // Run 2: abort with reset at round 10.
        for (int c = 0; c < 40 && !(rk_valid && rk_idx == 5'd10); c++) @(negedge clk);
        check("reach_round10", 32'(rk_idx), 32'd10);
        check("round10_key", 32'(rk_out), 32'(exp_rk[10]));
        #1 reset = 1'b0;
        #1;
        check("arst_start_ready", 32'(start_ready), 32'd1);
        check("arst_lfsr_set",    32'(lfsr_set),    32'd0);
        check("arst_rk_valid",    32'(rk_valid),    32'd0);
        check("arst_rk_out",      32'(rk_out),      32'd0);
        check("arst_rk_idx",      32'(rk_idx),      32'd0);
        check("arst_done",        32'(done),        32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("abort_no_done", done_seen, 0);

        // Run 3: restart after abort regenerates keys from round 0.
        start  = 1'b1;
        key_in = KEY_A;
        @(negedge clk);
        start = 1'b0;
        check("reprime_lfsr_set", 32'(lfsr_set), 32'd1);
        @(negedge clk);
        check("restart_rk0", 32'(rk_out), 32'h0100);
        wait_done();
        repeat (3) @(negedge clk);
        #1;
        check("run3_done_count", done_seen, 1);
`ifdef SIMECK_KS_KEY_ZEROIZE_EN
        check("idle_rk_out_zero", 32'(rk_out), 32'd0);
`else
        check("idle_rk_out_hold", 32'(rk_out), 32'(exp_rk[NR-1]));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simeck_key_schedule.md
Name: simeck_key_schedule

Overview:
- Simeck32/64 round-key generator; sits directly downstream of the 5-bit z-sequence LFSR and consumes its 1-bit output once per round.
- Accepts a 64-bit master key, primes the LFSR through its `set` input, then emits one 16-bit round key per cycle for NUM_ROUNDS cycles.
- The encrypt/decrypt datapath consumes the round keys; the decrypter buffers them in reverse order.

Parameters:
- WORD_W, 16: key word width n.
- NUM_ROUNDS, 32: round keys emitted per key load.
- ROT_A, 5: left-rotate amount for the AND term of f.
- ROT_B, 1: left-rotate amount for the XOR term of f.

Ports:
- clk  in  1: clock.
- reset  in  1: async reset. Active-low: 0 = reset asserted.
- start  in  1: load request; accepted only when start_ready=1.
- key_in  in  4*WORD_W: master key = {t2,t1,t0,k0}; k0 = key_in[WORD_W-1:0].
- start_ready  out  1: high in IDLE.
- lfsr_set  out  1: drives LFSR `set`; high for exactly 1 cycle (PRIME).
- z_in  in  1: LFSR output bit.
- rk_valid  out  1: round key valid.
- rk_out  out  WORD_W: round key k_i.
- rk_idx  out  5: round index i.
- done  out  1: 1-cycle pulse after the last round key.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (reset=0 asserts).
- Reset values: state=IDLE, all key registers 0, round counter 0, start_ready=1, lfsr_set=0, rk_valid=0, rk_out=0, rk_idx=0, done=0.
- FSM states: IDLE, PRIME, RUN, DONE.
- IDLE:
  - start=1 latches key_in into k0/t0/t1/t2 and moves to PRIME.
  - start while not in IDLE is ignored (no queueing).
- PRIME:
  - lfsr_set=1 for this cycle only; next state RUN.
  - The LFSR loads 11111 at the following edge, so z_in is valid (z_0=1) in the first RUN cycle.
- RUN, cycle i = 0..NUM_ROUNDS-1:
  - rk_valid=1, rk_out=k0 (k_i), rk_idx=i.
  - z_in is sampled at this edge.
  - Register update: k0<=t0; t0<=t1; t1<=t2; t2<=k0 ^ f(t0) ^ C ^ {WORD_W-1 zeros, z_in}.
  - f(x) = (x & rotl(x,ROT_A)) ^ rotl(x,ROT_B), where rotl is a left rotate in WORD_W bits.
  - C = 2^WORD_W - 4 (16'hFFFC); all arithmetic is bitwise, with no carries.
  - After i = NUM_ROUNDS-1, go to DONE.
- DONE: done=1, rk_valid=0 for 1 cycle; next state IDLE. start_ready returns to 1 the cycle after DONE.
- Latency: start accepted at edge T → rk_valid first high in cycle T+2 → done high in cycle T+2+NUM_ROUNDS.
- No backpressure: the LFSR free-runs, so round keys stream on consecutive cycles with no gaps.
- Reset mid-operation (PRIME or RUN): return to the reset values immediately; lfsr_set drops asynchronously; no done pulse.
- Round counter: rk_idx never exceeds NUM_ROUNDS-1; it resets to 0 on each accepted start.

Optional Feature:
- Macro: SIMECK_KS_KEY_ZEROIZE_EN.
- Defined: in DONE, k0/t0/t1/t2 are cleared to 0 and rk_out is forced to 0 whenever rk_valid=0.
- Undefined: key registers retain their final state after DONE, and rk_out holds the last round key.

Decomposition:
- Shared package simeck_pkg contains:
  - WORD_W default and the C constant.
  - State enum {IDLE, PRIME, RUN, DONE}.
  - Round-function helper f(x) with rotl.
- One sub-module: simeck_round_f, combinational f(x), reused by the encrypt/decrypt datapath.

Test Plan:
- Known key: key_in=64'h1918_1110_0908_0100 with a live LFSR → rk_out sequence starts 0x0100, 0x0908, 0x1110, 0x1918 at rk_idx 0..3. All 32 keys match the golden Simeck32/64 model; done pulses once.
- Timing: start at edge T → lfsr_set=1 only in cycle T+1; rk_valid high continuously for exactly 32 cycles starting at T+2; done at T+34.
- Busy start: start pulsed during RUN → ignored; the key sequence is unchanged and start_ready=0 until after DONE.
- Reset mid-RUN: reset=0 at round 10 → all outputs take their reset values asynchronously. A new start afterwards regenerates the round keys from round 0, including re-priming via lfsr_set.
- Back-to-back: a second start in the cycle start_ready returns (after DONE) → the second run produces identical round keys.
- Macro SIMECK_KS_KEY_ZEROIZE_EN defined: after done, internal key registers == 0 and rk_out == 0. Undefined: rk_out holds round key 31.
